// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Brief    : Shared types and constants for the push-button conditioning path.
// Revision : 1.0
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

    localparam int MODE_BTN_IDX = 4;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One button: 2-flop synchronizer, debounce FSM, level/press/release.
// Revision : 1.0
// ============================================================================
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    dbnc_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn_raw;
            r_sync2   <= r_sync1;
            // Pulses are single-cycle: cleared every cycle unless re-set below.
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state <= PRESSED;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= PRESSED;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state   <= IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Front-panel button conditioning; one independent debouncer per bit.
// Revision : 1.0
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 5,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_btn_raw(btn_raw[g]),
            .o_level  (btn_level[g]),
            .o_press  (btn_press[g]),
            .o_release(btn_release[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Revision : 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int N   = 5;
    localparam int DC  = 4;
    localparam int LAT = DC + 3;   // negedge drive -> pulse visible at negedge

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    ev_t exp_q[$];

    button_conditioner #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pulses are matched against expectations in order of arrival.
    always @(negedge clk) begin
        ev_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_pulse cyc=%0d got none, required press=%b release=%b",
                     e.cyc, e.press, e.rel);
        end
        if (btn_press !== '0 || btn_release !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b, required none",
                         cyc, btn_press, btn_release);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.press !== btn_press || e.rel !== btn_release) begin
                    n_err++;
                    $display("FAIL pulse cyc=%0d press=%b release=%b, required cyc=%0d press=%b release=%b",
                             cyc, btn_press, btn_release, e.cyc, e.press, e.rel);
                end
            end
        end
    end

    task automatic expect_pulse(input int at, input logic [N-1:0] p, input logic [N-1:0] r);
        ev_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        btn_raw = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_press, btn_release} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d got %b/%b/%b, required all 0",
                         cyc, btn_level, btn_press, btn_release);
            end
        end
        rst = 1'b1;
        expect_pulse(cyc + LAT, 5'b11111, 5'b00000);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== 5'b11111) begin
            n_err++;
            $display("FAIL reset_fresh_level got %b, required 11111", btn_level);
        end
        btn_raw = '0;
        expect_pulse(cyc + LAT, 5'b00000, 5'b11111);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== '0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_release got level=%b pending=%0d, required 00000/0",
                     btn_level, exp_q.size());
        end
    endtask

    task automatic test_clean_press();
        int           k;
        logic [N-1:0] exp_lvl;
        k = cyc;
        btn_raw[2] = 1'b1;
        expect_pulse(k + LAT, 5'b00100, 5'b00000);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            exp_lvl = (i >= LAT && i < 20 + LAT) ? 5'b00100 : 5'b00000;
            n_cmp++;
            if (btn_level !== exp_lvl) begin
                n_err++;
                $display("FAIL clean_level cyc=%0d got %b, required %b", cyc, btn_level, exp_lvl);
            end
            if (i == 20) begin
                btn_raw[2] = 1'b0;
                expect_pulse(cyc + LAT, 5'b00000, 5'b00100);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clean_pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int           k;
        logic [N-1:0] exp_lvl;
        k = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(k + 4 + LAT, 5'b00001, 5'b00000);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_lvl = (i >= 4 + LAT) ? 5'b00001 : 5'b00000;
            n_cmp++;
            if (btn_level !== exp_lvl) begin
                n_err++;
                $display("FAIL bounce_level cyc=%0d got %b, required %b", cyc, btn_level, exp_lvl);
            end
            if (i <= 4) btn_raw[0] = (i % 2 == 0);
        end
        btn_raw[0] = 1'b0;
        expect_pulse(cyc + LAT, 5'b00000, 5'b00001);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== '0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bounce_end got level=%b pending=%0d, required 00000/0",
                     btn_level, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        btn_raw[4] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 3) btn_raw[4] = 1'b0;
            n_cmp++;
            if (btn_level !== '0) begin
                n_err++;
                $display("FAIL glitch_level cyc=%0d got %b, required 00000", cyc, btn_level);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [N-1:0] exp_lvl;
        btn_raw[1] = 1'b1;
        expect_pulse(cyc + LAT, 5'b00010, 5'b00000);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            exp_lvl = (i >= LAT) ? 5'b00010 : 5'b00000;
            n_cmp++;
            if (btn_level !== exp_lvl) begin
                n_err++;
                $display("FAIL relbounce_level cyc=%0d got %b, required %b", cyc, btn_level, exp_lvl);
            end
            if (i == 12) btn_raw[1] = 1'b0;
            if (i == 14) btn_raw[1] = 1'b1;
        end
        btn_raw[1] = 1'b0;
        expect_pulse(cyc + LAT, 5'b00000, 5'b00010);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== '0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL relbounce_end got level=%b pending=%0d, required 00000/0",
                     btn_level, exp_q.size());
        end
    endtask

    task automatic test_simultaneous_reset();
        int           m;
        logic [N-1:0] exp_lvl;
        btn_raw = 5'b01001;
        expect_pulse(cyc + LAT, 5'b01001, 5'b00000);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== 5'b01001) begin
            n_err++;
            $display("FAIL simul_level got %b, required 01001", btn_level);
        end
        btn_raw = '0;
        expect_pulse(cyc + LAT, 5'b00000, 5'b01001);
        run_cycles(LAT + 3);
        // Reset lands while bit 3 is counting in PRESS_WAIT.
        m = cyc;
        btn_raw[3] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_lvl = (i >= 6 + LAT) ? 5'b01000 : 5'b00000;
            n_cmp++;
            if (btn_level !== exp_lvl) begin
                n_err++;
                $display("FAIL midreset_level cyc=%0d got %b, required %b", cyc, btn_level, exp_lvl);
            end
            if (i == 4) rst = 1'b0;
            if (i == 6) begin
                rst = 1'b1;
                expect_pulse(m + 6 + LAT, 5'b01000, 5'b00000);
            end
        end
        btn_raw[3] = 1'b0;
        expect_pulse(cyc + LAT, 5'b00000, 5'b01000);
        run_cycles(LAT + 3);
        n_cmp++;
        if (btn_level !== '0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_end got level=%b pending=%0d, required 00000/0",
                     btn_level, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_bounce();
        test_simultaneous_reset();
        run_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
